// File: rtl/multi_limit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_limit_pkg
// Description : Shared types for the multi-channel laser pulse limit checker:
//               per-channel FSM states, fault codes and the fault-code
//               priority helper used by the fault log.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_limit_pkg;

  // Per-channel measurement state.
  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_HIGH    = 2'd1,
    ST_LOW     = 2'd2
  } ch_state_t;

  // Fault codes double as bit positions in a channel's 4-bit flag vector.
  typedef enum logic [1:0] {
    FC_WIDTH_LO  = 2'd0,
    FC_WIDTH_HI  = 2'd1,
    FC_PERIOD_LO = 2'd2,
    FC_PERIOD_HI = 2'd3
  } fault_code_t;

  localparam int c_num_codes = 4;

  // Lowest-numbered fault code present in a flag vector (FC_WIDTH_LO if none).
  function automatic fault_code_t first_code(input logic [c_num_codes-1:0] v);
    fault_code_t c;
    c = FC_WIDTH_LO;
    for (int k = c_num_codes - 1; k >= 0; k--) begin
      if (v[k]) begin
        c = fault_code_t'(k[1:0]);
      end
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_limit_channel.sv
`default_nettype none
// ============================================================================
// Module      : pulse_limit_channel
// Description : One laser-pulse channel: two-stage sampling with edge detect,
//               UNARMED/HIGH/LOW measurement FSM, saturating width and period
//               counters, sticky fail flags and in-range window outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_limit_channel
  import multi_limit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   pulse_i,
  input  logic [CNT_W-1:0]       width_min_i,
  input  logic [CNT_W-1:0]       width_max_i,
  input  logic [CNT_W-1:0]       period_min_i,
  input  logic [CNT_W-1:0]       period_max_i,
  output logic [c_num_codes-1:0] flags_o,
  output logic                   width_window_o,
  output logic                   period_window_o
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};

  ch_state_t              state_q, state_d;
  logic                   samp_q, prev_q;
  logic [CNT_W-1:0]       width_q, width_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [c_num_codes-1:0] flags_q, flags_d;
  logic [c_num_codes-1:0] w_viol;

  logic                   w_rise, w_fall;
  logic                   w_width_inv, w_period_inv;
  logic [CNT_W-1:0]       w_width_inc, w_period_inc;

  assign w_rise       = samp_q & ~prev_q;
  assign w_fall       = ~samp_q & prev_q;
  // Inverted limit windows make every checked edge fail its lower bound.
  assign w_width_inv  = (width_min_i > width_max_i);
  assign w_period_inv = (period_min_i > period_max_i);
  assign w_width_inc  = (width_q == c_cnt_max) ? width_q : width_q + c_one;
  assign w_period_inc = (period_q == c_cnt_max) ? period_q : period_q + c_one;

  // Next state, counters and violations of the sample currently registered.
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    period_d = period_q;
    w_viol   = '0;
    case (state_q)
      ST_UNARMED: begin
        if (w_rise) begin
          state_d  = ST_HIGH;
          width_d  = c_one;
          period_d = c_one;
        end
      end
      ST_HIGH: begin
        period_d = w_period_inc;
        if (w_period_inc > period_max_i) begin
          w_viol[FC_PERIOD_HI] = 1'b1;
        end
        if (w_fall) begin
          state_d = ST_LOW;
          if ((width_q < width_min_i) || w_width_inv) begin
            w_viol[FC_WIDTH_LO] = 1'b1;
          end
        end else begin
          width_d = w_width_inc;
          if (w_width_inc > width_max_i) begin
            w_viol[FC_WIDTH_HI] = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (w_rise) begin
          state_d  = ST_HIGH;
          width_d  = c_one;
          period_d = c_one;
          if ((period_q < period_min_i) || w_period_inv) begin
            w_viol[FC_PERIOD_LO] = 1'b1;
          end
        end else begin
          period_d = w_period_inc;
          if (w_period_inc > period_max_i) begin
            w_viol[FC_PERIOD_HI] = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_UNARMED;
      end
    endcase

    // A disabled channel never reports; a clear re-arms from scratch, but a
    // violation found in the clear cycle still lands in the flags below.
    if (!enable_i) begin
      w_viol = '0;
    end
    if (!enable_i || clear_i) begin
      state_d  = ST_UNARMED;
      width_d  = '0;
      period_d = '0;
    end
    flags_d = (clear_i ? '0 : flags_q) | w_viol;
  end

  // Sample pipeline, FSM state, counters and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_UNARMED;
      samp_q   <= 1'b0;
      prev_q   <= 1'b0;
      width_q  <= '0;
      period_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      samp_q   <= pulse_i;
      prev_q   <= samp_q;
      width_q  <= width_d;
      period_q <= period_d;
      flags_q  <= flags_d;
    end
  end

  assign flags_o         = flags_q;
  assign width_window_o  = (state_q == ST_HIGH) &&
                           (width_q >= width_min_i) && (width_q <= width_max_i);
  assign period_window_o = (state_q != ST_UNARMED) &&
                           (period_q >= period_min_i) && (period_q <= period_max_i);

endmodule
`default_nettype wire

// File: rtl/multi_limit_check.sv
`default_nettype none
// ============================================================================
// Module      : multi_limit_check
// Description : NUM_CH independent laser-pulse width/period limit checkers
//               with shared limits, aggregated fail output and an optional
//               first-fault log.
//               Optional feature macro: MULTI_LIMIT_CHECK_FAULT_LOG_EN
//               (defined: fault log active; undefined: log outputs tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module multi_limit_check
  import multi_limit_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_fail,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] laser_pulse,
  input  logic [CNT_W-1:0]  width_min,
  input  logic [CNT_W-1:0]  width_max,
  input  logic [CNT_W-1:0]  period_min,
  input  logic [CNT_W-1:0]  period_max,
  output logic [NUM_CH-1:0] fail_width_lo,
  output logic [NUM_CH-1:0] fail_width_hi,
  output logic [NUM_CH-1:0] fail_period_lo,
  output logic [NUM_CH-1:0] fail_period_hi,
  output logic              any_fail,
  output logic [NUM_CH-1:0] width_window,
  output logic [NUM_CH-1:0] period_window,
  output logic              first_fault_valid,
  output logic [3:0]        first_fault_ch,
  output logic [1:0]        first_fault_code
);

  logic [NUM_CH-1:0][c_num_codes-1:0] w_flags;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_limit_channel #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk             (clk),
      .rst             (rst),
      .clear_i         (clear_fail),
      .enable_i        (ch_enable[g]),
      .pulse_i         (laser_pulse[g]),
      .width_min_i     (width_min),
      .width_max_i     (width_max),
      .period_min_i    (period_min),
      .period_max_i    (period_max),
      .flags_o         (w_flags[g]),
      .width_window_o  (width_window[g]),
      .period_window_o (period_window[g])
    );
    assign fail_width_lo[g]  = w_flags[g][FC_WIDTH_LO];
    assign fail_width_hi[g]  = w_flags[g][FC_WIDTH_HI];
    assign fail_period_lo[g] = w_flags[g][FC_PERIOD_LO];
    assign fail_period_hi[g] = w_flags[g][FC_PERIOD_HI];
  end

  assign any_fail = |w_flags;

`ifdef MULTI_LIMIT_CHECK_FAULT_LOG_EN
  logic        log_valid_q, log_valid_d;
  logic [3:0]  log_ch_q, log_ch_d;
  fault_code_t log_code_q, log_code_d;

  // Flags were all zero since the last clear, so the first non-zero flag set
  // seen while the log is empty is exactly the first fault batch. Scanning
  // downward lets the lowest channel overwrite higher ones.
  always_comb begin
    log_valid_d = clear_fail ? 1'b0 : log_valid_q;
    log_ch_d    = clear_fail ? 4'd0 : log_ch_q;
    log_code_d  = clear_fail ? FC_WIDTH_LO : log_code_q;
    if (!clear_fail && !log_valid_q) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (|w_flags[i]) begin
          log_valid_d = 1'b1;
          log_ch_d    = 4'(i);
          log_code_d  = first_code(w_flags[i]);
        end
      end
    end
  end

  // Fault log registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_valid_q <= 1'b0;
      log_ch_q    <= 4'd0;
      log_code_q  <= FC_WIDTH_LO;
    end else begin
      log_valid_q <= log_valid_d;
      log_ch_q    <= log_ch_d;
      log_code_q  <= log_code_d;
    end
  end

  assign first_fault_valid = log_valid_q;
  assign first_fault_ch    = log_ch_q;
  assign first_fault_code  = log_code_q;
`else
  assign first_fault_valid = 1'b0;
  assign first_fault_ch    = 4'd0;
  assign first_fault_code  = 2'd0;
`endif

endmodule
`default_nettype wire
